// File: rtl/bwt_occ_builder.sv
// BWT occurrence-table builder: streams symbols, writes running per-symbol counts to
// the OCC SRAM, then writes the 4-entry C table. Define OCC_SAMPLE_EN for a 4x sampled OCC.
module bwt_occ_builder #(
  parameter int REF_NUM    = 1024,
  parameter int REF_LENGTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [1:0]              in_sym,
  output logic                    in_ready,
  output logic                    occ_wEn,
  output logic [REF_LENGTH-1:0]   occ_wAddr,
  output logic [4*REF_LENGTH-1:0] occ_wData,
  output logic                    c_wEn,
  output logic [1:0]              c_wAddr,
  output logic [REF_LENGTH-1:0]   c_wData,
  output logic                    busy,
  output logic                    done
);

  // Index is one bit wider so REF_NUM == 2^REF_LENGTH is representable.
  localparam int IW = REF_LENGTH + 1;
  localparam logic [IW-1:0] NUM  = IW'(REF_NUM);
  localparam logic [IW-1:0] LAST = IW'(REF_NUM - 1);

  typedef enum logic [1:0] {IDLE, FILL, CTAB, DONE} state_e;

  state_e                       state_q, state_d;
  logic [3:0][REF_LENGTH-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [2:0]                   cptr_q, cptr_d;
  logic                         occ_wEn_q, occ_wEn_d;
  logic [REF_LENGTH-1:0]        occ_wAddr_q, occ_wAddr_d;
  logic [4*REF_LENGTH-1:0]      occ_wData_q, occ_wData_d;
  logic                         c_wEn_q, c_wEn_d;
  logic [1:0]                   c_wAddr_q, c_wAddr_d;
  logic [REF_LENGTH-1:0]        c_wData_q, c_wData_d;
  logic [3:0][REF_LENGTH-1:0]   cbase;
  logic                         accept;

  assign in_ready  = (state_q == FILL) && (idx_q < NUM);
  assign accept    = in_ready && in_valid;
  assign busy      = (state_q == FILL) || (state_q == CTAB);
  assign done      = (state_q == DONE);
  assign occ_wEn   = occ_wEn_q;
  assign occ_wAddr = occ_wAddr_q;
  assign occ_wData = occ_wData_q;
  assign c_wEn     = c_wEn_q;
  assign c_wAddr   = c_wAddr_q;
  assign c_wData   = c_wData_q;

  // C[c] is the wrapped sum of final counts of all symbols lexically below c.
  always_comb begin
    cbase[0] = '0;
    cbase[1] = cnt_q[0];
    cbase[2] = cnt_q[0] + cnt_q[1];
    cbase[3] = cnt_q[0] + cnt_q[1] + cnt_q[2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    cptr_d      = cptr_q;
    occ_wEn_d   = 1'b0;
    occ_wAddr_d = '0;
    occ_wData_d = '0;
    c_wEn_d     = 1'b0;
    c_wAddr_d   = '0;
    c_wData_d   = '0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = '0;
          idx_d   = '0;
          cptr_d  = '0;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_d[in_sym] = cnt_q[in_sym] + REF_LENGTH'(1);
          idx_d         = idx_q + IW'(1);
`ifdef OCC_SAMPLE_EN
          occ_wEn_d   = (idx_q[1:0] == 2'b11);
          occ_wAddr_d = REF_LENGTH'(idx_q >> 2);
`else
          occ_wEn_d   = 1'b1;
          occ_wAddr_d = idx_q[REF_LENGTH-1:0];
`endif
          occ_wData_d = occ_wEn_d ? cnt_d : '0;
          if (idx_q == LAST) state_d = CTAB;
        end
      end
      CTAB: begin
        // Writes are registered, so the last OCC row lands on the first CTAB cycle
        // and C entries follow one cycle later without ever overlapping it.
        if (cptr_q[2]) begin
          state_d = DONE;
          cptr_d  = '0;
        end else begin
          c_wEn_d   = 1'b1;
          c_wAddr_d = cptr_q[1:0];
          c_wData_d = cbase[cptr_q[1:0]];
          cptr_d    = cptr_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      cptr_q      <= '0;
      occ_wEn_q   <= 1'b0;
      occ_wAddr_q <= '0;
      occ_wData_q <= '0;
      c_wEn_q     <= 1'b0;
      c_wAddr_q   <= '0;
      c_wData_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cptr_q      <= cptr_d;
      occ_wEn_q   <= occ_wEn_d;
      occ_wAddr_q <= occ_wAddr_d;
      occ_wData_q <= occ_wData_d;
      c_wEn_q     <= c_wEn_d;
      c_wAddr_q   <= c_wAddr_d;
      c_wData_q   <= c_wData_d;
    end
  end

endmodule

// File: tb/tb_bwt_occ_builder.sv
// Self-checking bench for bwt_occ_builder (REF_NUM=8, REF_LENGTH=3); expectations come
// from a counting model over the symbol stream. Honours OCC_SAMPLE_EN like the design.
module tb_bwt_occ_builder;

  localparam int N = 8;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           in_valid = 1'b0;
  logic [1:0]     in_sym = 2'd0;
  logic           in_ready;
  logic           occ_wEn;
  logic [L-1:0]   occ_wAddr;
  logic [4*L-1:0] occ_wData;
  logic           c_wEn;
  logic [1:0]     c_wAddr;
  logic [L-1:0]   c_wData;
  logic           busy;
  logic           done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int overlap = 0;
  int occAddrQ[$], occDataQ[$], occCycQ[$];
  int cAddrQ[$], cDataQ[$], cCycQ[$];
  int accCyc[$];

  bwt_occ_builder #(.REF_NUM(N), .REF_LENGTH(L)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_sym(in_sym),
    .in_ready(in_ready), .occ_wEn(occ_wEn), .occ_wAddr(occ_wAddr), .occ_wData(occ_wData),
    .c_wEn(c_wEn), .c_wAddr(c_wAddr), .c_wData(c_wData), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write monitor: records every SRAM write with the cycle it was seen in.
  always @(negedge clk) begin
    if (occ_wEn === 1'b1) begin
      occAddrQ.push_back(int'(occ_wAddr));
      occDataQ.push_back(int'(occ_wData));
      occCycQ.push_back(cyc);
    end
    if (c_wEn === 1'b1) begin
      cAddrQ.push_back(int'(c_wAddr));
      cDataQ.push_back(int'(c_wData));
      cCycQ.push_back(cyc);
    end
    if (occ_wEn === 1'b1 && c_wEn === 1'b1) overlap++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*L+6:0] allOutputs();
    return {in_ready, occ_wEn, occ_wAddr, occ_wData, c_wEn, c_wAddr, c_wData, busy, done};
  endfunction

  task automatic clearCapture();
    occAddrQ.delete(); occDataQ.delete(); occCycQ.delete();
    cAddrQ.delete(); cDataQ.delete(); cCycQ.delete();
    accCyc.delete();
    overlap = 0;
  endtask

  // Full build: start, stream the symbols (gapMode 0 none, 1 alternate, 2 random),
  // optionally pulse start at symbol startAt, then compare against the model.
  task automatic run_build(input logic [1:0] syms[N], input int gapMode, input int startAt,
                           input string name);
    int i, budget, readyDrop, w, nExp;
    int cnt[4];
    int expAddr[$], expData[$], expCyc[$];
    logic v;
    clearCapture();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_start: done/busy/rdy=%b%b%b required 011", name, done, busy, in_ready);
    end
    i = 0; budget = 0; readyDrop = 0;
    while (i < N && budget < 200) begin
      case (gapMode)
        0: v = 1'b1;
        1: v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_sym   = syms[i];
      start    = (i == startAt);
      if (in_ready !== 1'b1) readyDrop++;
      if (v && in_ready === 1'b1) begin
        accCyc.push_back(cyc);
        i++;
      end
      budget++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    total++;
    if (i != N) begin
      bad++;
      $display("[TB] FAIL %s_accept: accepted %0d required %0d", name, i, N);
    end
    total++;
    if (readyDrop != 0) begin
      bad++;
      $display("[TB] FAIL %s_ready: in_ready low %0d times during FILL, required 0", name, readyDrop);
    end
    w = 0;
    while (done !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s_done: done/busy/rdy=%b%b%b required 100", name, done, busy, in_ready);
    end

    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < N && k < accCyc.size(); k++) begin
      cnt[syms[k]] = (cnt[syms[k]] + 1) % 8;
`ifdef OCC_SAMPLE_EN
      if (k % 4 == 3) begin
        expAddr.push_back(k / 4);
`else
      begin
        expAddr.push_back(k);
`endif
        expData.push_back((cnt[3] << 9) | (cnt[2] << 6) | (cnt[1] << 3) | cnt[0]);
        expCyc.push_back(accCyc[k] + 1);
      end
    end
    nExp = expAddr.size();
    total++;
    if (occAddrQ.size() != nExp) begin
      bad++;
      $display("[TB] FAIL %s_occ_count: got %0d writes required %0d", name, occAddrQ.size(), nExp);
    end
    for (int k = 0; k < nExp && k < occAddrQ.size(); k++) begin
      total++;
      if (occAddrQ[k] != expAddr[k] || occDataQ[k] != expData[k] || occCycQ[k] != expCyc[k]) begin
        bad++;
        $display("[TB] FAIL %s_occ%0d: addr=%0d data=%03h cyc=%0d required addr=%0d data=%03h cyc=%0d",
                 name, k, occAddrQ[k], occDataQ[k], occCycQ[k], expAddr[k], expData[k], expCyc[k]);
      end
    end
    total++;
    if (cAddrQ.size() != 4) begin
      bad++;
      $display("[TB] FAIL %s_c_count: got %0d writes required 4", name, cAddrQ.size());
    end
    for (int c = 0; c < 4 && c < cAddrQ.size(); c++) begin
      int base;
      base = 0;
      for (int s = 0; s < c; s++) base += cnt[s];
      base = base % 8;
      total++;
      if (cAddrQ[c] != c || cDataQ[c] != base || cCycQ[c] != cCycQ[0] + c ||
          (occCycQ.size() > 0 && cCycQ[c] <= occCycQ[occCycQ.size()-1])) begin
        bad++;
        $display("[TB] FAIL %s_c%0d: addr=%0d data=%0d cyc=%0d required addr=%0d data=%0d consecutive after OCC",
                 name, c, cAddrQ[c], cDataQ[c], cCycQ[c], c, base);
      end
    end
    total++;
    if (overlap != 0) begin
      bad++;
      $display("[TB] FAIL %s_overlap: %0d cycles with both strobes, required 0", name, overlap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total++;
    if (allOutputs() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_outputs: got %h required 0", allOutputs());
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (allOutputs() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_idle: got %h required 0", allOutputs());
    end
  endtask

  task automatic test_basic();
    logic [1:0] s[N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    run_build(s, 0, -1, "basic");
  endtask

  task automatic test_gaps();
    logic [1:0] s[N] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    run_build(s, 1, -1, "gaps");
  endtask

  task automatic test_wrap();
    logic [1:0] s[N] = '{default: 2'd3};
    run_build(s, 0, -1, "wrap");
  endtask

  task automatic test_reset_mid_build();
    logic [1:0] s[N] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sym = s[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (allOutputs() !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_async: got %h required 0", allOutputs());
    end
    @(negedge clk);
    rst = 1'b1;
    clearCapture();
    repeat (4) @(negedge clk);
    total++;
    if (occAddrQ.size() != 0 || cAddrQ.size() != 0 || allOutputs() !== '0) begin
      bad++;
      $display("[TB] FAIL midreset_abandon: writes=%0d outputs=%h required 0 and 0",
               occAddrQ.size() + cAddrQ.size(), allOutputs());
    end
    run_build(s, 0, -1, "rebuild");
  endtask

  task automatic test_start_ignored();
    logic [1:0] s[N] = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [1:0] r[N];
    run_build(s, 0, 3, "midstart");
    for (int k = 0; k < N; k++) r[k] = 2'($urandom_range(0, 3));
    run_build(r, 1, -1, "restart");
  endtask

  task automatic test_random();
    logic [1:0] r[N];
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < N; k++) r[k] = 2'($urandom_range(0, 3));
      run_build(r, 2, -1, $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_reset_mid_build();
    test_start_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
